text_writer: RTL and testbench
==============================

# text_writer

Writer side of the 80x25 character screen buffer: accepts a byte stream from the host/UART side, interprets printable ASCII and a minimal set of control codes, and issues single-cycle writes into the character RAM that the video scan-out reads. Maintains the cursor position and a circular first-row offset so that scrolling never copies memory. The block sits between the serial receiver and the dual-port screen RAM; the display side consumes `first_row` to start scan-out at the correct physical row.

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 25, rows per screen
- `ADDR_W`, 11, RAM address width (must satisfy COLS*ROWS <= 2^ADDR_W)
- `clk`  in  1  system clock
- `clr`  in  1  reset, asynchronous, active-high
- `in_data`  in  8  incoming character
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block can accept a character this cycle
- `wr_en`  out  1  RAM write strobe, one cycle per write
- `wr_addr`  out  ADDR_W  RAM address, phys_row*COLS + col
- `wr_data`  out  8  RAM write data
- `cursor_x`  out  7  logical cursor column, 0..COLS-1
- `cursor_y`  out  5  logical cursor row, 0..ROWS-1
- `first_row`  out  5  physical RAM row shown as screen row 0

## Operation
- States: INIT (fill whole RAM with 0x20), IDLE (accept bytes), CLEAR (fill one row with 0x20 after scroll).
- Transfer occurs on a rising edge with `in_valid && in_ready`. `in_ready` = 1 only in IDLE.
- Physical row = (first_row + cursor_y) mod ROWS; computed without a divider (add, subtract ROWS if >= ROWS).
- Byte handling in IDLE:
  - 0x20..0x7E: write at cursor; cursor_x increments if < COLS-1, otherwise stays at COLS-1 (next printable overwrites last column).
  - 0x0D CR: cursor_x = 0.
  - 0x0A LF: if cursor_y < ROWS-1, cursor_y+1. Else scroll: first_row = (first_row+1) mod ROWS, cursor_y unchanged, enter CLEAR targeting the old first_row (new bottom row).
  - 0x08 BS: cursor_x-1 if > 0, else unchanged. No erase.
  - 0x09 TAB: cursor_x = min((cursor_x | 7) + 1, COLS-1).
  - All other bytes: consumed, no effect.
- INIT: counter 0..COLS*ROWS-1, one write per cycle, then IDLE. CLEAR: COLS writes at row base, then IDLE.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cursor_x`=0, `cursor_y`=0, `first_row`=0; state INIT.
- All outputs registered. Printable char accepted at edge N -> `wr_en`=1 during cycle N+1 with address from pre-increment cursor; cursor outputs updated at edge N.
- Printable throughput: 1 char/cycle, `in_ready` stays high.
- Scrolling LF accepted at edge N -> `in_ready`=0 from N+1 for exactly COLS cycles; writes in cycles N+1..N+COLS, addresses ascending; `in_ready`=1 again in cycle N+COLS+1.
- INIT: `in_ready`=0 for COLS*ROWS cycles after reset release, writes addresses 0..COLS*ROWS-1 in order.
- `clr` mid-INIT/CLEAR/IDLE: immediate return to reset values, INIT restarts from address 0.
- first_row wraps ROWS-1 -> 0.

## Configuration
- `TEXT_WRITER_AUTOWRAP_EN` defined: printable char written at cursor_x = COLS-1 sets cursor_x = 0 and performs the LF action (including scroll/CLEAR when cursor_y = ROWS-1).
- Undefined: cursor sticks at last column as above.

## Structure
- Shared package `text_pkg`: COLS, ROWS, ADDR_W defaults, control code constants (CHR_CR, CHR_LF, CHR_BS, CHR_TAB, CHR_SPACE), state enum.
- One sub-module: `text_addr` (registered row-base/offset calculation: phys_row*COLS + col via mod-ROWS add and shift-add for COLS=80).

## Test plan
- Reset release -> 2000 writes of 0x20, addresses 0..1999, `in_ready` rises in cycle 2001.
- Send "AB" back-to-back -> writes 0x41@0, 0x42@1 on consecutive cycles; cursor_x=2.
- Cursor at (79,0), send 'X','Y' -> writes @79 twice (AUTOWRAP off); with AUTOWRAP on, 'Y' @80, cursor (1,1).
- cursor_y=24, first_row=0, send LF -> first_row=1, 80 writes of 0x20 @0..79, `in_ready` low 80 cycles; next 'Z' at x=0 written @0.
- first_row=24, cursor_y=24, cursor_x=5, send CR, TAB, TAB, BS -> cursor_x 0,8,16,15; LF -> first_row=0, clear @1920..1999.
- Assert `clr` mid-CLEAR -> outputs return to reset values, INIT restarts at address 0.

Source files
------------

// File: rtl/text_pkg.sv
// Shared definitions for the character-screen writer: geometry defaults,
// control codes and the writer state encoding.
package text_pkg;

  localparam int TEXT_COLS   = 80;
  localparam int TEXT_ROWS   = 25;
  localparam int TEXT_ADDR_W = 11;

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_TAB   = 8'h09;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_CLEAR
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHR_SPACE) && (c <= CHR_TILDE);
  endfunction

endpackage

// File: rtl/text_addr.sv
// Registered RAM address: ((base + row) mod ROWS) * COLS + col.
// The modulo is a single conditional subtract; COLS=80 uses shift-add.
module text_addr
  import text_pkg::*;
#(
  parameter int COLS   = TEXT_COLS,
  parameter int ROWS   = TEXT_ROWS,
  parameter int ADDR_W = TEXT_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [4:0]        base,
  input  logic [4:0]        row,
  input  logic [6:0]        col,
  output logic [ADDR_W-1:0] addr
);

  logic [5:0]        sum;
  logic [5:0]        phys;
  logic [ADDR_W-1:0] phys_w;
  logic [ADDR_W-1:0] col_w;
  logic [ADDR_W-1:0] row_off;

  always_comb begin
    sum  = {1'b0, base} + {1'b0, row};
    phys = (sum >= 6'(ROWS)) ? (sum - 6'(ROWS)) : sum;
  end

  assign phys_w = ADDR_W'(phys);
  assign col_w  = ADDR_W'(col);

  generate
    if (COLS == 80) begin : g_shift_add
      assign row_off = (phys_w << 6) + (phys_w << 4);
    end else begin : g_mul
      assign row_off = phys_w * ADDR_W'(COLS);
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr) addr <= '0;
    else     addr <= row_off + col_w;
  end

endmodule

// File: rtl/text_writer.sv
// Byte-stream writer for the 80x25 screen RAM with cursor and circular
// first-row scrolling. Define TEXT_WRITER_AUTOWRAP_EN to wrap at the last column.
module text_writer
  import text_pkg::*;
#(
  parameter int COLS   = TEXT_COLS,
  parameter int ROWS   = TEXT_ROWS,
  parameter int ADDR_W = TEXT_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [6:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic [4:0]        first_row
);

  localparam logic [6:0] X_LAST = 7'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

  state_t     state;
  logic [6:0] col_cnt;
  logic [4:0] row_cnt;
  logic [4:0] clear_row;
  logic       fill_last;

  logic       xfer;
  logic       scroll_lf;
  logic [4:0] a_base;
  logic [4:0] a_row;
  logic [6:0] a_col;
  logic [7:0] tab_x;
  logic [4:0] first_row_inc;

  assign xfer          = in_valid && in_ready;
  assign scroll_lf     = xfer && (in_data == CHR_LF) && (cursor_y == Y_LAST);
  assign tab_x         = ({1'b0, cursor_x} | 8'h07) + 8'h01;
  assign first_row_inc = (first_row == Y_LAST) ? 5'd0 : first_row + 5'd1;

  // A scrolling LF writes column 0 of the old first row on its own edge,
  // so the clear burst lines up with the cycle after acceptance.
  always_comb begin
    a_base = first_row;
    a_row  = cursor_y;
    a_col  = cursor_x;
    unique case (state)
      ST_INIT: begin
        a_base = 5'd0;
        a_row  = row_cnt;
        a_col  = col_cnt;
      end
      ST_CLEAR: begin
        a_base = clear_row;
        a_row  = 5'd0;
        a_col  = col_cnt;
      end
      default: begin
        if (scroll_lf) begin
          a_row = 5'd0;
          a_col = 7'd0;
        end
      end
    endcase
  end

  text_addr #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk  (clk),
    .clr  (clr),
    .base (a_base),
    .row  (a_row),
    .col  (a_col),
    .addr (wr_addr)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= ST_INIT;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_data   <= 8'h00;
      cursor_x  <= 7'd0;
      cursor_y  <= 5'd0;
      first_row <= 5'd0;
      col_cnt   <= 7'd0;
      row_cnt   <= 5'd0;
      clear_row <= 5'd0;
      fill_last <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        ST_INIT: begin
          if (fill_last) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            fill_last <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_data <= CHR_SPACE;
            if (col_cnt == X_LAST) begin
              col_cnt <= 7'd0;
              if (row_cnt == Y_LAST) fill_last <= 1'b1;
              else                   row_cnt   <= row_cnt + 5'd1;
            end else begin
              col_cnt <= col_cnt + 7'd1;
            end
          end
        end

        ST_CLEAR: begin
          if (fill_last) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            fill_last <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_data <= CHR_SPACE;
            if (col_cnt == X_LAST) fill_last <= 1'b1;
            else                   col_cnt   <= col_cnt + 7'd1;
          end
        end

        default: begin
          if (xfer) begin
            if (is_printable(in_data)) begin
              wr_en   <= 1'b1;
              wr_data <= in_data;
              if (cursor_x != X_LAST) begin
                cursor_x <= cursor_x + 7'd1;
              end
`ifdef TEXT_WRITER_AUTOWRAP_EN
              else begin
                cursor_x <= 7'd0;
                if (cursor_y != Y_LAST) begin
                  cursor_y <= cursor_y + 5'd1;
                end else begin
                  clear_row <= first_row;
                  first_row <= first_row_inc;
                  col_cnt   <= 7'd0;
                  fill_last <= 1'b0;
                  state     <= ST_CLEAR;
                  in_ready  <= 1'b0;
                end
              end
`endif
            end else begin
              unique case (in_data)
                CHR_CR: cursor_x <= 7'd0;
                CHR_LF: begin
                  if (cursor_y != Y_LAST) begin
                    cursor_y <= cursor_y + 5'd1;
                  end else begin
                    wr_en     <= 1'b1;
                    wr_data   <= CHR_SPACE;
                    clear_row <= first_row;
                    first_row <= first_row_inc;
                    col_cnt   <= 7'd1;
                    fill_last <= 1'b0;
                    state     <= ST_CLEAR;
                    in_ready  <= 1'b0;
                  end
                end
                CHR_BS: begin
                  if (cursor_x != 7'd0) cursor_x <= cursor_x - 7'd1;
                end
                CHR_TAB: cursor_x <= (tab_x > {1'b0, X_LAST}) ? X_LAST : tab_x[6:0];
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: init fill, printing, control codes,
// scrolling with row clear, and reset during a clear burst.
module tb_text_writer;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [4:0]  first_row;

  int n_checks = 0;
  int n_errors = 0;
  int q_addr[$];
  int q_data[$];
  int q_cyc[$];
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  text_writer dut (
    .clk       (clk),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .first_row (first_row)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(int'(wr_addr));
      q_data.push_back(int'(wr_data));
      q_cyc.push_back(int'(cyc));
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  initial begin
    int n;
    int bad;
    string s;

    clr      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_cursor", int'({cursor_x, cursor_y}), 0);
    check("rst_first_row", int'(first_row), 0);

    // Init fill: 2000 spaces at 0..1999, ready in cycle 2001
    clear_log();
    clr = 1'b0;
    wait_ready(n);
    check("init_ready_cycle", n, 2001);
    check("init_write_count", q_addr.size(), 2000);
    bad = 0;
    foreach (q_addr[i]) if (q_addr[i] != i || q_data[i] != 32'h20) bad++;
    check("init_sequence", bad, 0);

    // Back-to-back printable
    clear_log();
    send("A");
    send("B");
    @(negedge clk);
    check("ab_count", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      check("a_addr", q_addr[0], 0);
      check("a_data", q_data[0], 8'h41);
      check("b_addr", q_addr[1], 1);
      check("b_data", q_data[1], 8'h42);
      check("ab_consecutive", q_cyc[1] - q_cyc[0], 1);
    end
    check("ab_cursor_x", int'(cursor_x), 2);
    check("ab_in_ready", int'(in_ready), 1);

    // Tab stops from x=2 up to the last column
    send(8'h09);
    check("tab_first", int'(cursor_x), 8);
    repeat (8) send(8'h09);
    check("tab_72", int'(cursor_x), 72);
    send(8'h09);
    check("tab_clamp", int'(cursor_x), 79);

    // Last column behaviour
    clear_log();
    send("X");
    send("Y");
    @(negedge clk);
    check("xy_count", q_addr.size(), 2);
`ifdef TEXT_WRITER_AUTOWRAP_EN
    if (q_addr.size() == 2) begin
      check("x_addr", q_addr[0], 79);
      check("y_addr_wrap", q_addr[1], 80);
    end
    check("xy_cursor_x", int'(cursor_x), 1);
    check("xy_cursor_y", int'(cursor_y), 1);
`else
    if (q_addr.size() == 2) begin
      check("x_addr", q_addr[0], 79);
      check("y_addr_stick", q_addr[1], 79);
      check("y_data", q_data[1], 8'h59);
    end
    check("xy_cursor_x", int'(cursor_x), 79);
    check("xy_cursor_y", int'(cursor_y), 0);
`endif

    // Walk down to the bottom row
    send(8'h0D);
    n = 0;
    while (cursor_y != 5'd24 && n < 30) begin
      send(8'h0A);
      n++;
    end
    check("bottom_y", int'(cursor_y), 24);
    check("bottom_first_row", int'(first_row), 0);

    // Scrolling LF with first_row=0
    clear_log();
    send(8'h0A);
    wait_ready(n);
    @(negedge clk);
    check("scroll_busy_cycles", n, 80);
    check("scroll_first_row", int'(first_row), 1);
    check("scroll_cursor_y", int'(cursor_y), 24);
    check("scroll_count", q_addr.size(), 80);
    bad = 0;
    foreach (q_addr[i]) if (q_addr[i] != i || q_data[i] != 32'h20) bad++;
    check("scroll_clear_seq", bad, 0);
    if (q_cyc.size() == 80) check("scroll_contiguous", q_cyc[79] - q_cyc[0], 79);

    clear_log();
    send("Z");
    @(negedge clk);
    check("z_count", q_addr.size(), 1);
    if (q_addr.size() == 1) check("z_addr", q_addr[0], 0);

    // Scroll 23 more times to reach first_row=24
    for (int k = 0; k < 23; k++) begin
      send(8'h0A);
      wait_ready(n);
    end
    check("wrap_first_row_24", int'(first_row), 24);

    s = "hello";
    send(8'h0D);
    for (int k = 0; k < 5; k++) send(s[k]);
    check("x5", int'(cursor_x), 5);
    send(8'h0D);
    check("cr_x", int'(cursor_x), 0);
    send(8'h09);
    check("tab_x8", int'(cursor_x), 8);
    send(8'h09);
    check("tab_x16", int'(cursor_x), 16);
    send(8'h08);
    check("bs_x15", int'(cursor_x), 15);
    clear_log();
    send(8'h07);
    @(negedge clk);
    check("ignored_x", int'(cursor_x), 15);
    check("ignored_no_write", q_addr.size(), 0);
    send(8'h0D);
    send(8'h08);
    check("bs_at_zero", int'(cursor_x), 0);

    // Scroll with first_row wrapping 24 -> 0, clearing physical row 24
    clear_log();
    send(8'h0A);
    wait_ready(n);
    @(negedge clk);
    check("wrap_first_row_0", int'(first_row), 0);
    check("wrap_clear_count", q_addr.size(), 80);
    if (q_addr.size() == 80) begin
      check("wrap_clear_first", q_addr[0], 1920);
      check("wrap_clear_last", q_addr[79], 1999);
    end

    // Reset in the middle of a clear burst
    send(8'h0A);
    repeat (20) @(negedge clk);
    check("pre_clr_busy", int'(in_ready), 0);
    clr = 1'b1;
    #1;
    check("midclr_in_ready", int'(in_ready), 0);
    check("midclr_wr_en", int'(wr_en), 0);
    check("midclr_wr_addr", int'(wr_addr), 0);
    check("midclr_cursor", int'({cursor_x, cursor_y}), 0);
    check("midclr_first_row", int'(first_row), 0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("reinit_wr_en", int'(wr_en), 1);
    check("reinit_addr0", int'(wr_addr), 0);
    repeat (2) @(negedge clk);
    check("reinit_addr2", int'(wr_addr), 2);
    check("reinit_busy", int'(in_ready), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
